// File: rtl/udp_pkg.sv
// Shared UDP definitions used by the transmit and receive framers.
package udp_pkg;

  localparam int UDP_PORT_W    = 16;
  localparam int UDP_LEN_W     = 16;
  localparam int UDP_CRC_W     = 16;
  localparam int UDP_HDR_LEN   = 8;
  localparam int UDP_HDR_BEATS = 2;

  // One-hot encoding so a single bit test selects each output mux leg.
  typedef enum logic [3:0] {
    UDP_ST_IDLE  = 4'b0001,
    UDP_ST_H0    = 4'b0010,
    UDP_ST_H1    = 4'b0100,
    UDP_ST_PLOAD = 4'b1000
  } udp_state_e;

  // UDP length field covers header plus payload; wraps mod 2^16.
  function automatic logic [UDP_LEN_W-1:0] udp_total_len(input logic [UDP_LEN_W-1:0] pload_len);
    return pload_len + UDP_LEN_W'(UDP_HDR_LEN);
  endfunction

endpackage

// File: rtl/udp_tx.sv
// UDP transmit framer: emits the two-beat UDP header, then passes the payload through.
//
// state    | meaning
// IDLE     | waiting for a header request (hdr_ready_o high)
// H0       | presenting {src_port, dst_port}
// H1       | presenting {udp_len, checksum=0}
// PLOAD    | combinational payload pass-through until the last beat
module udp_tx
  import udp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hdr_valid_i,
  output logic                  hdr_ready_o,
  input  logic [UDP_PORT_W-1:0] src_port_i,
  input  logic [UDP_PORT_W-1:0] dst_port_i,
  input  logic [UDP_LEN_W-1:0]  len_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  last_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [KEEP_W-1:0]     keep_i,
  input  logic                  cancel_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [KEEP_W-1:0]     keep_o
);

  if (DATA_W != 32) begin : g_bad_width
    $error("udp_tx: only DATA_W = 32 is supported");
  end

  udp_state_e            state_q, state_d;
  logic [UDP_PORT_W-1:0] src_q, src_d;
  logic [UDP_PORT_W-1:0] dst_q, dst_d;
  logic [UDP_LEN_W-1:0]  len_q, len_d;
  logic                  empty_q, empty_d;
  logic                  hdr_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UDP_ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      empty_q <= empty_d;
    end
  end

  always_comb begin
    hdr_load = (state_q == UDP_ST_IDLE) && hdr_valid_i;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    empty_d  = empty_q;
    if (hdr_load) begin
      src_d   = src_port_i;
      dst_d   = dst_port_i;
      len_d   = udp_total_len(len_i);
      empty_d = (len_i == '0);
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_ready_o = 1'b0;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    last_o      = 1'b0;
    data_o      = '0;
    keep_o      = '0;

    case (state_q)
      UDP_ST_IDLE: begin
        hdr_ready_o = 1'b1;
        if (hdr_valid_i) state_d = UDP_ST_H0;
      end

      UDP_ST_H0: begin
        valid_o = 1'b1;
        data_o  = {src_q, dst_q};
        keep_o  = '1;
        if (cancel_i) begin
          valid_o = 1'b0;
          state_d = UDP_ST_IDLE;
        end else if (ready_i) begin
          state_d = UDP_ST_H1;
        end
      end

      UDP_ST_H1: begin
        valid_o = 1'b1;
        data_o  = {len_q, {UDP_CRC_W{1'b0}}};
        keep_o  = '1;
        last_o  = empty_q;
        if (cancel_i) begin
          valid_o = 1'b0;
          state_d = UDP_ST_IDLE;
        end else if (ready_i) begin
          state_d = empty_q ? UDP_ST_IDLE : UDP_ST_PLOAD;
        end
      end

      UDP_ST_PLOAD: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
        last_o  = last_i;
        // keep_i is only meaningful on the final beat; earlier beats are full words
        keep_o  = last_i ? keep_i : '1;
        if (cancel_i) begin
          valid_o = 1'b0;
          ready_o = 1'b0;
          state_d = UDP_ST_IDLE;
        end else if (valid_i && ready_i && last_i) begin
          state_d = UDP_ST_IDLE;
        end
      end

      default: state_d = UDP_ST_IDLE;
    endcase
  end

  a_state_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(state_q));

  a_valid_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(valid_o));

  a_beat_known: assert property (@(posedge clk) disable iff (reset)
    valid_o |-> !$isunknown({last_o, keep_o}));

  a_hdr_stable: assert property (@(posedge clk) disable iff (reset)
    ((state_q == UDP_ST_H0 || state_q == UDP_ST_H1) && valid_o && !ready_i)
      |=> (cancel_i || (valid_o && $stable(data_o) && $stable(keep_o) && $stable(last_o))));

endmodule

// File: tb/tb_udp_tx.sv
// Self-checking bench for udp_tx: scoreboard of expected datagram beats plus scenario tasks.
module tb_udp_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        hdr_valid_i, hdr_ready_o;
  logic [15:0] src_port_i, dst_port_i, len_i;
  logic        valid_i, ready_o, last_i;
  logic [31:0] data_i;
  logic [3:0]  keep_i;
  logic        cancel_i;
  logic        valid_o, ready_i, last_o;
  logic [31:0] data_o;
  logic [3:0]  keep_o;

  always #5 clk = ~clk;

  udp_tx #(.DATA_W(32), .KEEP_W(4)) dut (
    .clk(clk), .reset(reset),
    .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o),
    .src_port_i(src_port_i), .dst_port_i(dst_port_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i),
    .data_i(data_i), .keep_i(keep_i), .cancel_i(cancel_i),
    .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .data_o(data_o), .keep_o(keep_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] pay_q[$];
  bit          rdy_pat[$];
  int          total = 0;
  int          bad = 0;

  logic        hold_chk = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_keep;
  logic        hold_last;

  // Output monitor: pops the scoreboard on every accepted beat and checks stall stability.
  always @(negedge clk) begin : mon
    beat_t e;
    if (reset !== 1'b0) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk && cancel_i === 1'b0) begin
        total++;
        if (valid_o !== 1'b1 || data_o !== hold_data || keep_o !== hold_keep || last_o !== hold_last) begin
          bad++;
          $display("FAIL hold_stable: got v=%b d=%h k=%b l=%b, required v=1 d=%h k=%b l=%b",
                   valid_o, data_o, keep_o, last_o, hold_data, hold_keep, hold_last);
        end
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h l=%b, required no beat", data_o, last_o);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e.data || keep_o !== e.keep || last_o !== e.last) begin
            bad++;
            $display("FAIL beat: got d=%h k=%b l=%b, required d=%h k=%b l=%b",
                     data_o, keep_o, last_o, e.data, e.keep, e.last);
          end
        end
      end
      hold_chk  = (valid_o === 1'b1 && ready_i === 1'b0);
      hold_data = data_o;
      hold_keep = keep_o;
      hold_last = last_o;
    end
  end

  function automatic logic next_rdy(input bit rand_rdy);
    if (rdy_pat.size() != 0) return rdy_pat.pop_front();
    return rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Presents a header and returns just after the handshake edge.
  task automatic do_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    int guard = 0;
    @(posedge clk); #1;
    hdr_valid_i = 1'b1; src_port_i = src; dst_port_i = dst; len_i = len;
    @(negedge clk);
    while (hdr_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 50) begin
      bad++;
      $display("FAIL hdr_timeout: hdr_ready_o=%b, required 1 within 50 cycles", hdr_ready_o);
    end
    @(posedge clk); #1;
    hdr_valid_i = 1'b0;
  endtask

  // Sends one datagram whose payload words are taken from pay_q.
  task automatic run_dgram(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                           input logic [3:0] klast, input bit rand_rdy);
    int n = pay_q.size();
    int idx = 0;
    int guard = 0;
    bit acc;
    bit saw_rdy = 1'b0;
    exp_q.push_back('{{src, dst}, 4'hF, 1'b0});
    exp_q.push_back('{{len + 16'd8, 16'h0000}, 4'hF, (n == 0)});
    for (int k = 0; k < n; k++)
      exp_q.push_back('{pay_q[k], (k == n - 1) ? klast : 4'hF, (k == n - 1)});
    do_hdr(src, dst, len);
    ready_i = next_rdy(rand_rdy);
    if (n > 0) begin
      valid_i = 1'b1; data_i = pay_q[0]; last_i = (n == 1);
      keep_i = (n == 1) ? klast : 4'($urandom);
    end
    @(negedge clk); #1;
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("FAIL h0_latency: valid_o=%b after header accept, required 1", valid_o);
    end
    while ((idx < n || exp_q.size() != 0) && guard < 200) begin
      acc = (valid_i === 1'b1 && ready_o === 1'b1);
      if (ready_o === 1'b1) saw_rdy = 1'b1;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < n) begin
          data_i = pay_q[idx]; last_i = (idx == n - 1);
          keep_i = (idx == n - 1) ? klast : 4'($urandom);
        end else begin
          valid_i = 1'b0; last_i = 1'b0;
        end
      end
      ready_i = next_rdy(rand_rdy);
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL dgram_timeout: %0d beats left, required 0", exp_q.size());
      exp_q.delete();
    end
    valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
    if (n == 0) begin
      @(negedge clk);
      if (ready_o === 1'b1) saw_rdy = 1'b1;
      total++;
      if (saw_rdy || hdr_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL zero_len_idle: saw_ready=%b hdr_ready_o=%b, required 0 and 1", saw_rdy, hdr_ready_o);
      end
    end
    pay_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; hdr_valid_i = 0; src_port_i = 0; dst_port_i = 0; len_i = 0;
    valid_i = 0; last_i = 0; data_i = 0; keep_i = 0; cancel_i = 0; ready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (hdr_ready_o !== 1'b1) begin bad++; $display("FAIL rst_hdr_ready: got %b, required 1", hdr_ready_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", valid_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b, required 0", ready_o); end
    total++; if (last_o !== 1'b0) begin bad++; $display("FAIL rst_last: got %b, required 0", last_o); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL rst_data: got %h, required 0", data_o); end
    total++; if (keep_o !== 4'h0) begin bad++; $display("FAIL rst_keep: got %b, required 0", keep_o); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    pay_q.push_back(32'hAABBCCDD);
    pay_q.push_back(32'hEE000000);
    run_dgram(16'h1234, 16'h5678, 16'd5, 4'b1000, 1'b0);
  endtask

  task automatic test_zero_len();
    run_dgram(16'h00AA, 16'h00BB, 16'd0, 4'hF, 1'b0);
  endtask

  task automatic test_backpressure();
    rdy_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pay_q.push_back($urandom);
    pay_q.push_back($urandom);
    run_dgram(16'hBEEF, 16'hCAFE, 16'd7, 4'b1110, 1'b0);
  endtask

  task automatic test_len_wrap();
    pay_q.push_back($urandom);
    run_dgram(16'h0001, 16'h0002, 16'hFFFC, 4'b1100, 1'b0);
  endtask

  task automatic test_cancel();
    logic [31:0] p0 = $urandom;
    logic [31:0] p1 = $urandom;
    exp_q.push_back('{32'h0A0B0C0D, 4'hF, 1'b0});
    exp_q.push_back('{32'h00140000, 4'hF, 1'b0});
    exp_q.push_back('{p0, 4'hF, 1'b0});
    do_hdr(16'h0A0B, 16'h0C0D, 16'd12);
    ready_i = 1'b1; valid_i = 1'b1; data_i = p0; last_i = 1'b0; keep_i = 4'hF;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    data_i = p1; cancel_i = 1'b1;
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL cancel_valid: got %b, required 0", valid_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL cancel_ready: got %b, required 0", ready_o); end
    @(posedge clk); #1;
    cancel_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    total++; if (hdr_ready_o !== 1'b1) begin bad++; $display("FAIL cancel_idle: hdr_ready_o=%b, required 1", hdr_ready_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL cancel_after: valid_o=%b, required 0", valid_o); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cancel_beats: %0d beats left, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p0 = $urandom;
    int c = 0, last_c = -1, h0b_c = -1, guard = 0;
    bit acc, drop;
    exp_q.push_back('{32'h01010202, 4'hF, 1'b0});
    exp_q.push_back('{32'h000C0000, 4'hF, 1'b0});
    exp_q.push_back('{p0, 4'hF, 1'b1});
    exp_q.push_back('{32'h03030404, 4'hF, 1'b0});
    exp_q.push_back('{32'h00080000, 4'hF, 1'b1});
    @(posedge clk); #1;
    hdr_valid_i = 1'b1; src_port_i = 16'h0101; dst_port_i = 16'h0202; len_i = 16'd4;
    @(negedge clk);
    while (hdr_ready_o !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    src_port_i = 16'h0303; dst_port_i = 16'h0404; len_i = 16'd0;
    valid_i = 1'b1; data_i = p0; last_i = 1'b1; keep_i = 4'hF; ready_i = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk); #1;
      c++; guard++;
      if (last_c >= 0 && h0b_c < 0 && valid_o === 1'b1 && data_o === 32'h03030404) h0b_c = c;
      acc = (valid_i === 1'b1 && ready_o === 1'b1);
      if (acc) last_c = c;
      drop = (last_c >= 0 && hdr_ready_o === 1'b1);
      @(posedge clk); #1;
      if (acc) begin valid_i = 1'b0; last_i = 1'b0; end
      if (drop) hdr_valid_i = 1'b0;
    end
    hdr_valid_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
    total++;
    if (guard >= 40 || last_c < 0 || h0b_c - last_c != 2) begin
      bad++;
      $display("FAIL b2b_gap: last beat at %0d second H0 at %0d, required gap 2", last_c, h0b_c);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_pload();
    logic [31:0] p0 = $urandom;
    logic [31:0] p1 = $urandom;
    exp_q.push_back('{32'h11112222, 4'hF, 1'b0});
    exp_q.push_back('{32'h00100000, 4'hF, 1'b0});
    exp_q.push_back('{p0, 4'hF, 1'b0});
    do_hdr(16'h1111, 16'h2222, 16'd8);
    ready_i = 1'b1; valid_i = 1'b1; data_i = p0; last_i = 1'b0; keep_i = 4'hF;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    data_i = p1; last_i = 1'b1; keep_i = 4'b1010; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (hdr_ready_o !== 1'b1) begin bad++; $display("FAIL rstp_hdr_ready: got %b, required 1", hdr_ready_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rstp_valid: got %b, required 0", valid_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rstp_ready: got %b, required 0", ready_o); end
    total++; if (last_o !== 1'b0 || data_o !== 32'h0 || keep_o !== 4'h0) begin
      bad++; $display("FAIL rstp_beat: got l=%b d=%h k=%b, required 0 0 0", last_o, data_o, keep_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; last_i = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rstp_beats: %0d beats left, required 0", exp_q.size()); exp_q.delete(); end
    pay_q.push_back($urandom);
    run_dgram(16'h3333, 16'h4444, 16'd3, 4'b1110, 1'b0);
  endtask

  task automatic test_random();
    for (int d = 0; d < 4; d++) begin
      int n = $urandom_range(1, 6);
      int nb = $urandom_range(1, 4);
      logic [3:0] kl = 4'(4'hF << (4 - nb));
      for (int k = 0; k < n; k++) pay_q.push_back($urandom);
      run_dgram(16'($urandom), 16'($urandom), 16'((n - 1) * 4 + nb), kl, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_len_wrap();
    test_cancel();
    test_back_to_back();
    test_reset_pload();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
